// File: rtl/pe_types.sv
// Shared pe_array types: result words, result vectors and result-drain FSM states.
package pe_types;

  localparam int unsigned PE_NUM_RESULTS  = 4;
  localparam int unsigned PE_RESULT_WIDTH = 32;

  typedef logic [PE_RESULT_WIDTH-1:0] pe_result_t;
  typedef pe_result_t [PE_NUM_RESULTS-1:0] pe_result_vec_t;

  typedef enum logic [0:0] {
    DRAIN_IDLE,
    DRAIN_SHIFT
  } drain_state_t;

endpackage

// File: rtl/pe_vec_fifo.sv
// Vector FIFO with independent read/write pointers and a registered read port.
module pe_vec_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 128,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == CNT_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the same edge reads the head entry out.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        rdata  <= mem[rd_ptr];
      end
      if (do_push && !do_pop) begin
        level <= level + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Buffers pe_array result vectors and serialises them one lane per beat onto a
// valid/ready stream, throttling the feature driver before the FIFO overflows.
module pe_result_drain
  import pe_types::*;
#(
  parameter  int unsigned NUM_RESULTS_PER_CYCLE = PE_NUM_RESULTS,
  parameter  int unsigned RESULT_WIDTH          = PE_RESULT_WIDTH,
  parameter  int unsigned FIFO_DEPTH            = 16,
  parameter  int unsigned STALL_MARGIN          = 8,
  localparam int unsigned CNT_W                 = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned LANE_W                = $clog2(NUM_RESULTS_PER_CYCLE)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    ivalid,
  input  logic [NUM_RESULTS_PER_CYCLE*RESULT_WIDTH-1:0] idata,
  output logic                                    iready,
  output logic                                    ovalid,
  input  logic                                    oready,
  output logic [RESULT_WIDTH-1:0]                 odata,
  output logic [LANE_W-1:0]                       olane,
  output logic                                    olast,
  output logic                                    overflow,
  output logic [CNT_W-1:0]                        level
);

  localparam int unsigned       VEC_W     = NUM_RESULTS_PER_CYCLE * RESULT_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_RESULTS_PER_CYCLE - 1);

  drain_state_t      state_q;
  drain_state_t      state_d;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_d;
  logic              ovalid_q;
  logic              ovalid_d;
  logic              overflow_q;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  // The FIFO read register holds the vector being serialised.
  logic [NUM_RESULTS_PER_CYCLE-1:0][RESULT_WIDTH-1:0] head_vec;

  pe_vec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VEC_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ivalid),
    .pop   (pop),
    .wdata (idata),
    .rdata (head_vec),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Throttle depends only on registered occupancy, never on ivalid.
  assign iready = (CNT_W'(FIFO_DEPTH) - level) >= CNT_W'(STALL_MARGIN);

  assign ovalid   = ovalid_q;
  assign olane    = lane_q;
  assign olast    = (lane_q == LAST_LANE);
  assign odata    = head_vec[lane_q];
  assign overflow = overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= DRAIN_IDLE;
      lane_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      ovalid_q <= ovalid_d;
    end
  end

  // A beat arriving at a full FIFO is lost unless the head leaves on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (ivalid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    ovalid_d = ovalid_q;
    pop      = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          lane_d   = '0;
          ovalid_d = 1'b1;
          state_d  = DRAIN_SHIFT;
        end
      end
      DRAIN_SHIFT: begin
        if (oready) begin
          if (lane_q != LAST_LANE) begin
            lane_d = lane_q + LANE_W'(1);
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            lane_d = '0;
          end else begin
            ovalid_d = 1'b0;
            state_d  = DRAIN_IDLE;
          end
        end
      end
      default: begin
        ovalid_d = 1'b0;
        state_d  = DRAIN_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain: a vector-queue reference model predicts
// acceptance, occupancy and the serial result order.
module tb_pe_result_drain;

  localparam int N      = 4;
  localparam int RW     = 32;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 8;
  localparam int CW     = 5;
  localparam int LW     = 2;

  typedef logic [N*RW-1:0] vec_t;
  typedef struct packed {
    logic [RW-1:0] d;
    logic [LW-1:0] lane;
    logic          last;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ivalid = 1'b0;
  vec_t          idata = '0;
  logic          oready = 1'b0;
  logic          iready;
  logic          ovalid;
  logic [RW-1:0] odata;
  logic [LW-1:0] olane;
  logic          olast;
  logic          overflow;
  logic [CW-1:0] level;

  pe_result_drain #(
    .NUM_RESULTS_PER_CYCLE (N),
    .RESULT_WIDTH          (RW),
    .FIFO_DEPTH            (DEPTH),
    .STALL_MARGIN          (MARGIN)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ivalid   (ivalid),
    .idata    (idata),
    .iready   (iready),
    .ovalid   (ovalid),
    .oready   (oready),
    .odata    (odata),
    .olane    (olane),
    .olast    (olast),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: buffered vectors, results left in the vector on the output,
  // and the expected serial result stream.
  vec_t m_fifo[$];
  int   m_cur_left = 0;
  logic m_overflow = 1'b0;
  exp_t exp_q[$];

  always @(posedge clock) begin
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_cur_left = 0;
      m_overflow = 1'b0;
    end else begin
      logic acc, take, was_full;
      acc      = (m_cur_left != 0) && oready;
      take     = ((m_cur_left == 0) || (acc && m_cur_left == 1)) && (m_fifo.size() != 0);
      was_full = (m_fifo.size() == DEPTH);
      if (acc) m_cur_left--;
      if (take) begin
        void'(m_fifo.pop_front());
        m_cur_left = N;
      end
      if (ivalid) begin
        if (!was_full || take) begin
          m_fifo.push_back(idata);
          for (int k = 0; k < N; k++)
            exp_q.push_back('{d: idata[k*RW +: RW], lane: LW'(k), last: (k == N-1)});
        end else begin
          m_overflow = 1'b1;
        end
      end
    end
  end

  // Monitor: cycle-level state checks plus scoreboard pop on every accepted result.
  logic          hold_pend = 1'b0;
  logic [RW-1:0] prev_data;
  logic [LW-1:0] prev_lane;
  int            run_cur = 0;
  int            run_max = 0;
  int            valid_cnt = 0;

  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      chk("ovalid", 64'(ovalid), 64'(m_cur_left != 0));
      chk("level", 64'(level), 64'(m_fifo.size()));
      chk("iready", 64'(iready), 64'((DEPTH - m_fifo.size()) >= MARGIN));
      chk("overflow", 64'(overflow), 64'(m_overflow));
      if (hold_pend) begin
        chk("hold_valid", 64'(ovalid), 64'(1));
        chk("hold_data", 64'(odata), 64'(prev_data));
        chk("hold_lane", 64'(olane), 64'(prev_lane));
      end
      hold_pend = ovalid && !oready;
      prev_data = odata;
      prev_lane = olane;
      if (ovalid) begin
        run_cur++;
        valid_cnt++;
        if (run_cur > run_max) run_max = run_cur;
      end else begin
        run_cur = 0;
      end
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(odata), 64'(0) - 64'(1));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("odata", 64'(odata), 64'(e.d));
          chk("olane", 64'(olane), 64'(e.lane));
          chk("olast", 64'(olast), 64'(e.last));
        end
      end
    end
  end

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < N; k++) v[k*RW +: RW] = RW'($urandom);
    return v;
  endfunction

  task automatic cyc(input logic iv, input vec_t d, input logic ord);
    ivalid = iv;
    idata  = d;
    oready = ord;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset  = 1'b1;
    ivalid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ivalid = 1'b0;
    oready = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_timeout", 64'(n < 400), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_odata", 64'(odata), 64'(0));
    chk("rst_olane", 64'(olane), 64'(0));
    chk("rst_olast", 64'(olast), 64'(0));
    chk("rst_ovalid", 64'(ovalid), 64'(0));
    chk("rst_iready", 64'(iready), 64'(1));
    @(posedge clock);
    #1;

    // T1 single vector, lane k = 0x11*k
    for (int k = 0; k < N; k++) v[k*RW +: RW] = RW'(32'h11 * k);
    cyc(1'b1, v, 1'b1);
    ivalid = 1'b0;
    @(negedge clock);
    chk("t1_ovalid_t1", 64'(ovalid), 64'(0));
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      chk("t1_ovalid", 64'(ovalid), 64'(1));
      chk("t1_odata", 64'(odata), 64'(32'h11 * k));
      chk("t1_olast", 64'(olast), 64'(k == N-1));
    end
    @(negedge clock);
    chk("t1_done_ovalid", 64'(ovalid), 64'(0));
    chk("t1_done_level", 64'(level), 64'(0));
    @(posedge clock);
    #1;

    // T2 backpressure with oready toggling
    for (int i = 0; i < 40; i++) cyc((i % 8 == 0) && (i < 24), rand_vec(), (i % 2 == 0));
    drain();

    // T3 fill with oready low; the last beat overflows
    for (int i = 0; i < 18; i++) cyc(1'b1, rand_vec(), 1'b0);
    ivalid = 1'b0;
    chk("t3_level", 64'(level), 64'(DEPTH));
    chk("t3_iready", 64'(iready), 64'(0));
    chk("t3_overflow", 64'(overflow), 64'(1));
    drain();

    // T6 reset mid-drain clears the sticky overflow and buffered data
    for (int i = 0; i < 6; i++) cyc(1'b1, rand_vec(), 1'b0);
    ivalid = 1'b0;
    chk("t6_level_pre", 64'(level), 64'(5));
    chk("t6_ovalid_pre", 64'(ovalid), 64'(1));
    pulse_reset();
    @(negedge clock);
    chk("t6_ovalid", 64'(ovalid), 64'(0));
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_overflow", 64'(overflow), 64'(0));
    chk("t6_iready", 64'(iready), 64'(1));
    @(posedge clock);
    #1;
    cyc(1'b1, rand_vec(), 1'b1);
    drain();

    // T4 full FIFO with a same-cycle pop on lane 3
    for (int i = 0; i < 17; i++) cyc(1'b1, rand_vec(), 1'b0);
    chk("t4_level_full", 64'(level), 64'(DEPTH));
    for (int i = 0; i < 3; i++) cyc(1'b0, rand_vec(), 1'b1);
    cyc(1'b1, rand_vec(), 1'b1);
    ivalid = 1'b0;
    oready = 1'b0;
    chk("t4_level", 64'(level), 64'(DEPTH));
    chk("t4_overflow", 64'(overflow), 64'(0));
    drain();

    // T5 back-to-back vectors, one beat every N cycles
    @(posedge clock);
    #1;
    run_cur   = 0;
    run_max   = 0;
    valid_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      cyc(1'b1, rand_vec(), 1'b1);
      for (int i = 0; i < N-1; i++) cyc(1'b0, rand_vec(), 1'b1);
    end
    drain();
    repeat (2) @(posedge clock);
    #1;
    chk("t5_valid_cycles", 64'(valid_cnt), 64'(32));
    chk("t5_longest_run", 64'(run_max), 64'(32));

    // Random traffic, including overflow episodes
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 2) == 0, rand_vec(), $urandom_range(0, 3) != 0);
    drain();
    pulse_reset();
    for (int i = 0; i < 300; i++)
      cyc(iready && ($urandom_range(0, 1) == 0), rand_vec(), $urandom_range(0, 1) == 0);
    drain();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
